// File: rtl/rampdp_param.sv
// rtl/rampdp_param.sv - parametrised 1R/1W RAM with power zones, retention, bypass and read-valid strobe
module rampdp_param #(
    parameter int DEPTH    = 32,
    parameter int WIDTH    = 256,
    parameter int NZONE    = 8,
    parameter int RD_PIPE  = 0,
    parameter int WAKE_CYC = 4,
    parameter int BYPASS   = 1,
    parameter int AW       = $clog2(DEPTH)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             RE,
    input  logic [AW-1:0]    RADR,
    input  logic             WE,
    input  logic [AW-1:0]    WADR,
    input  logic [WIDTH-1:0] WD,
    output logic [WIDTH-1:0] RD,
    output logic             RD_VLD,
    output logic             ERR,
    input  logic [NZONE-1:0] SLEEP_EN,
    input  logic             RET_EN,
    output logic [NZONE-1:0] ZONE_RDY,
    input  logic             IDDQ
);

    localparam int ZROWS = DEPTH / NZONE;
    localparam int CW    = (WAKE_CYC > 1) ? $clog2(WAKE_CYC) : 1;
    localparam int ZW    = (NZONE > 1) ? $clog2(NZONE) : 1;

    typedef enum logic [1:0] {
        ZS_ON   = 2'd0,
        ZS_OFF  = 2'd1,
        ZS_WAKE = 2'd2
    } zstate_t;

    zstate_t          zstate     [NZONE];
    zstate_t          zstate_nxt [NZONE];
    logic [CW-1:0]    zcnt       [NZONE];
    logic [CW-1:0]    zcnt_nxt   [NZONE];
    logic [NZONE-1:0] zone_on;
    logic [NZONE-1:0] zone_clr;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [DEPTH-1:0] row_vld;

    logic [ZW-1:0]    wr_zone;
    logic [ZW-1:0]    rd_zone;
    logic             wr_acc, wr_ok, wr_err;
    logic             rd_acc, rd_err;
    logic [WIDTH-1:0] rd_data;

    logic             s1_vld, s1_err, wr_err_q;
    logic [WIDTH-1:0] s1_data;

    always_comb begin
        for (int z = 0; z < NZONE; z++) begin
            zstate_nxt[z] = zstate[z];
            zcnt_nxt[z]   = zcnt[z];
            zone_clr[z]   = 1'b0;
            zone_on[z]    = (zstate[z] == ZS_ON);
            case (zstate[z])
                ZS_ON: begin
                    if (SLEEP_EN[z]) begin
                        zstate_nxt[z] = ZS_OFF;
                        zone_clr[z]   = !RET_EN;
                    end
                end
                ZS_OFF: begin
                    if (!SLEEP_EN[z]) begin
                        zstate_nxt[z] = ZS_WAKE;
                        zcnt_nxt[z]   = CW'(WAKE_CYC - 1);
                    end
                end
                ZS_WAKE: begin
                    if (SLEEP_EN[z]) begin
                        zstate_nxt[z] = ZS_OFF;
                        zone_clr[z]   = !RET_EN;
                    end else if (zcnt[z] == '0) begin
                        zstate_nxt[z] = ZS_ON;
                    end else begin
                        zcnt_nxt[z] = zcnt[z] - CW'(1);
                    end
                end
                default: zstate_nxt[z] = ZS_ON;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        for (int z = 0; z < NZONE; z++) begin
            if (RST) begin
                zstate[z] <= ZS_ON;
                zcnt[z]   <= '0;
            end else begin
                zstate[z] <= zstate_nxt[z];
                zcnt[z]   <= zcnt_nxt[z];
            end
        end
    end

    assign ZONE_RDY = zone_on;

    // Accesses see the registered zone state, so a transition takes effect one cycle later.
    assign wr_zone = ZW'(int'(WADR) / ZROWS);
    assign rd_zone = ZW'(int'(RADR) / ZROWS);
    assign wr_acc  = WE && !IDDQ;
    assign wr_ok   = wr_acc && zone_on[wr_zone];
    assign wr_err  = wr_acc && !zone_on[wr_zone];
    assign rd_acc  = RE && !IDDQ;
    assign rd_err  = rd_acc && !zone_on[rd_zone];

    always_comb begin
        rd_data = '0;
        if (!zone_on[rd_zone]) begin
            rd_data = '0;
        end else if ((BYPASS != 0) && wr_ok && (WADR == RADR)) begin
            rd_data = WD;
        end else if (row_vld[RADR]) begin
            rd_data = mem[RADR];
        end
    end

    always_ff @(posedge CLK) begin
        if (wr_ok && !RST) begin
            mem[WADR] <= WD;
        end
    end

    // A zone powering off without retention drops its rows, even one written that same cycle.
    always_ff @(posedge CLK) begin
        if (RST) begin
            row_vld <= '0;
        end else begin
            if (wr_ok) begin
                row_vld[WADR] <= 1'b1;
            end
            for (int r = 0; r < DEPTH; r++) begin
                if (zone_clr[r / ZROWS]) begin
                    row_vld[r] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            s1_vld   <= 1'b0;
            s1_err   <= 1'b0;
            s1_data  <= '0;
            wr_err_q <= 1'b0;
        end else begin
            s1_vld   <= rd_acc;
            s1_err   <= rd_err;
            wr_err_q <= wr_err;
            if (rd_acc) begin
                s1_data <= rd_data;
            end
        end
    end

    generate
        if (RD_PIPE == 0) begin : g_nopipe
            assign RD     = s1_data;
            assign RD_VLD = s1_vld;
            assign ERR    = s1_err || wr_err_q;
        end else begin : g_pipe
            logic             s2_vld, s2_err;
            logic [WIDTH-1:0] s2_data;

            always_ff @(posedge CLK) begin
                if (RST) begin
                    s2_vld  <= 1'b0;
                    s2_err  <= 1'b0;
                    s2_data <= '0;
                end else begin
                    s2_vld <= s1_vld;
                    s2_err <= s1_err;
                    if (s1_vld) begin
                        s2_data <= s1_data;
                    end
                end
            end

            assign RD     = s2_data;
            assign RD_VLD = s2_vld;
            assign ERR    = s2_err || wr_err_q;
        end
    endgenerate

endmodule

// File: tb/tb_rampdp_param.sv
// tb/tb_rampdp_param.sv - directed bench for rampdp_param (latency-1 bypass and latency-2 no-bypass builds)
module tb_rampdp_param;

    localparam int W = 256;
    localparam logic [W-1:0] D_A5 = {32{8'hA5}};
    localparam logic [W-1:0] D_11 = {32{8'h11}};
    localparam logic [W-1:0] D_22 = {32{8'h22}};
    localparam logic [W-1:0] D_5A = {32{8'h5A}};
    localparam logic [W-1:0] D_CC = {32{8'hCC}};
    localparam logic [W-1:0] D_33 = {32{8'h33}};
    localparam logic [W-1:0] D_FF = {32{8'hFF}};
    localparam logic [W-1:0] D_77 = {32{8'h77}};
    localparam logic [W-1:0] D_0  = '0;

    logic         CLK = 1'b0;
    logic         RST, RE, WE, RET_EN, IDDQ;
    logic [4:0]   RADR, WADR;
    logic [W-1:0] WD;
    logic [7:0]   SLEEP_EN;

    logic [W-1:0] rd0, rd1;
    logic         vld0, vld1, err0, err1;
    logic [7:0]   rdy0, rdy1;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    rampdp_param #(.RD_PIPE(0), .BYPASS(1)) u_dut0 (
        .CLK(CLK), .RST(RST), .RE(RE), .RADR(RADR), .WE(WE), .WADR(WADR), .WD(WD),
        .RD(rd0), .RD_VLD(vld0), .ERR(err0), .SLEEP_EN(SLEEP_EN), .RET_EN(RET_EN),
        .ZONE_RDY(rdy0), .IDDQ(IDDQ)
    );

    rampdp_param #(.RD_PIPE(1), .BYPASS(0)) u_dut1 (
        .CLK(CLK), .RST(RST), .RE(RE), .RADR(RADR), .WE(WE), .WADR(WADR), .WD(WD),
        .RD(rd1), .RD_VLD(vld1), .ERR(err1), .SLEEP_EN(SLEEP_EN), .RET_EN(RET_EN),
        .ZONE_RDY(rdy1), .IDDQ(IDDQ)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        tick();
        tick();
        checks++; if (rd0 !== D_0) begin errors++; $display("FAIL reset_rd0: got %h exp %h", rd0, D_0); end
        checks++; if (vld0 !== 1'b0) begin errors++; $display("FAIL reset_vld0: got %b exp 0", vld0); end
        checks++; if (err0 !== 1'b0) begin errors++; $display("FAIL reset_err0: got %b exp 0", err0); end
        checks++; if (rdy0 !== 8'hFF) begin errors++; $display("FAIL reset_rdy0: got %h exp ff", rdy0); end
        checks++; if (rd1 !== D_0) begin errors++; $display("FAIL reset_rd1: got %h exp %h", rd1, D_0); end
        checks++; if (vld1 !== 1'b0) begin errors++; $display("FAIL reset_vld1: got %b exp 0", vld1); end
        RST = 1'b0;
        tick();
    endtask

    task automatic test_write_read();
        WE = 1'b1; WADR = 5'd3; WD = D_A5;
        tick();
        WE = 1'b0; RE = 1'b1; RADR = 5'd3;
        tick();
        checks++; if (rd0 !== D_A5) begin errors++; $display("FAIL wr_rd3_d0: got %h exp %h", rd0, D_A5); end
        checks++; if (vld0 !== 1'b1) begin errors++; $display("FAIL wr_rd3_vld0: got %b exp 1", vld0); end
        checks++; if (err0 !== 1'b0) begin errors++; $display("FAIL wr_rd3_err0: got %b exp 0", err0); end
        checks++; if (vld1 !== 1'b0) begin errors++; $display("FAIL rd3_lat2_early_vld1: got %b exp 0", vld1); end
        RADR = 5'd4;
        tick();
        checks++; if (rd0 !== D_0) begin errors++; $display("FAIL rd4_unwritten_d0: got %h exp %h", rd0, D_0); end
        checks++; if (vld0 !== 1'b1) begin errors++; $display("FAIL rd4_vld0: got %b exp 1", vld0); end
        checks++; if (rd1 !== D_A5) begin errors++; $display("FAIL wr_rd3_d1: got %h exp %h", rd1, D_A5); end
        checks++; if (vld1 !== 1'b1) begin errors++; $display("FAIL wr_rd3_vld1: got %b exp 1", vld1); end
        RE = 1'b0;
        tick();
        checks++; if (vld0 !== 1'b0) begin errors++; $display("FAIL idle_vld0: got %b exp 0", vld0); end
        checks++; if (rd1 !== D_0) begin errors++; $display("FAIL rd4_unwritten_d1: got %h exp %h", rd1, D_0); end
        checks++; if (vld1 !== 1'b1) begin errors++; $display("FAIL rd4_vld1: got %b exp 1", vld1); end
        tick();
        checks++; if (rd1 !== D_0) begin errors++; $display("FAIL hold_rd1: got %h exp %h", rd1, D_0); end
        checks++; if (vld1 !== 1'b0) begin errors++; $display("FAIL idle_vld1: got %b exp 0", vld1); end
    endtask

    task automatic test_collision();
        WE = 1'b1; WADR = 5'd7; WD = D_11;
        tick();
        RE = 1'b1; RADR = 5'd7; WD = D_22;
        tick();
        checks++; if (rd0 !== D_22) begin errors++; $display("FAIL coll_bypass_d0: got %h exp %h", rd0, D_22); end
        WE = 1'b0;
        tick();
        checks++; if (rd1 !== D_11) begin errors++; $display("FAIL coll_old_d1: got %h exp %h", rd1, D_11); end
        checks++; if (rd0 !== D_22) begin errors++; $display("FAIL after_coll_d0: got %h exp %h", rd0, D_22); end
        RE = 1'b0;
        tick();
        checks++; if (rd1 !== D_22) begin errors++; $display("FAIL after_coll_d1: got %h exp %h", rd1, D_22); end
    endtask

    task automatic test_zone_sleep(input logic ret, input logic [W-1:0] exp_row0);
        RET_EN = ret;
        SLEEP_EN = 8'h01;
        tick();
        checks++; if (rdy0 !== 8'hFE) begin errors++; $display("FAIL sleep_rdy0 ret=%b: got %h exp fe", ret, rdy0); end
        tick();
        SLEEP_EN = 8'h00;
        for (int i = 1; i <= 5; i++) begin
            tick();
            checks++;
            if (rdy0[0] !== (i == 5)) begin
                errors++;
                $display("FAIL wake_rdy0 ret=%b cyc=%0d: got %b exp %b", ret, i, rdy0[0], (i == 5));
            end
        end
        checks++; if (rdy1 !== 8'hFF) begin errors++; $display("FAIL wake_rdy1 ret=%b: got %h exp ff", ret, rdy1); end
        RE = 1'b1; RADR = 5'd0;
        tick();
        RE = 1'b0;
        checks++; if (rd0 !== exp_row0) begin errors++; $display("FAIL retain_d0 ret=%b: got %h exp %h", ret, rd0, exp_row0); end
        tick();
        checks++; if (rd1 !== exp_row0) begin errors++; $display("FAIL retain_d1 ret=%b: got %h exp %h", ret, rd1, exp_row0); end
    endtask

    task automatic test_wake_error();
        SLEEP_EN = 8'h02;
        tick();
        SLEEP_EN = 8'h00;
        tick();
        WE = 1'b1; WADR = 5'd5; WD = D_CC;
        tick();
        checks++; if (err0 !== 1'b1) begin errors++; $display("FAIL wake_wr_err0: got %b exp 1", err0); end
        checks++; if (err1 !== 1'b1) begin errors++; $display("FAIL wake_wr_err1: got %b exp 1", err1); end
        checks++; if (rdy0[1] !== 1'b0) begin errors++; $display("FAIL wake_rdy_z1: got %b exp 0", rdy0[1]); end
        WE = 1'b0; RE = 1'b1; RADR = 5'd6;
        tick();
        checks++; if (rd0 !== D_0) begin errors++; $display("FAIL wake_rd_d0: got %h exp %h", rd0, D_0); end
        checks++; if (vld0 !== 1'b1) begin errors++; $display("FAIL wake_rd_vld0: got %b exp 1", vld0); end
        checks++; if (err0 !== 1'b1) begin errors++; $display("FAIL wake_rd_err0: got %b exp 1", err0); end
        checks++; if (err1 !== 1'b0) begin errors++; $display("FAIL wake_err1_gap: got %b exp 0", err1); end
        RE = 1'b0;
        tick();
        checks++; if (err0 !== 1'b0) begin errors++; $display("FAIL wake_err0_pulse: got %b exp 0", err0); end
        checks++; if (rd1 !== D_0) begin errors++; $display("FAIL wake_rd_d1: got %h exp %h", rd1, D_0); end
        checks++; if (vld1 !== 1'b1) begin errors++; $display("FAIL wake_rd_vld1: got %b exp 1", vld1); end
        checks++; if (err1 !== 1'b1) begin errors++; $display("FAIL wake_rd_err1: got %b exp 1", err1); end
        WE = 1'b1; WADR = 5'd8; WD = D_33;
        tick();
        checks++; if (err0 !== 1'b0) begin errors++; $display("FAIL z2_wr_err0: got %b exp 0", err0); end
        checks++; if (err1 !== 1'b0) begin errors++; $display("FAIL z2_wr_err1: got %b exp 0", err1); end
        checks++; if (rdy0 !== 8'hFF) begin errors++; $display("FAIL z1_ready: got %h exp ff", rdy0); end
        WE = 1'b0; RE = 1'b1; RADR = 5'd5;
        tick();
        checks++; if (rd0 !== D_0) begin errors++; $display("FAIL dropped_wr_d0: got %h exp %h", rd0, D_0); end
        RADR = 5'd8;
        tick();
        checks++; if (rd0 !== D_33) begin errors++; $display("FAIL z2_rd_d0: got %h exp %h", rd0, D_33); end
        checks++; if (rd1 !== D_0) begin errors++; $display("FAIL dropped_wr_d1: got %h exp %h", rd1, D_0); end
        RE = 1'b0;
        tick();
        checks++; if (rd1 !== D_33) begin errors++; $display("FAIL z2_rd_d1: got %h exp %h", rd1, D_33); end
    endtask

    task automatic test_iddq();
        IDDQ = 1'b1; RE = 1'b1; RADR = 5'd8; WE = 1'b1; WADR = 5'd8; WD = D_FF;
        tick();
        checks++; if (vld0 !== 1'b0) begin errors++; $display("FAIL iddq_vld0: got %b exp 0", vld0); end
        checks++; if (rd0 !== D_33) begin errors++; $display("FAIL iddq_hold_d0: got %h exp %h", rd0, D_33); end
        checks++; if (err0 !== 1'b0) begin errors++; $display("FAIL iddq_err0: got %b exp 0", err0); end
        tick();
        checks++; if (vld1 !== 1'b0) begin errors++; $display("FAIL iddq_vld1: got %b exp 0", vld1); end
        checks++; if (rd1 !== D_33) begin errors++; $display("FAIL iddq_hold_d1: got %h exp %h", rd1, D_33); end
        IDDQ = 1'b0; WE = 1'b0;
        tick();
        RE = 1'b0;
        checks++; if (rd0 !== D_33) begin errors++; $display("FAIL iddq_nowrite_d0: got %h exp %h", rd0, D_33); end
        tick();
        checks++; if (rd1 !== D_33) begin errors++; $display("FAIL iddq_nowrite_d1: got %h exp %h", rd1, D_33); end
    endtask

    task automatic test_reset_mid();
        WE = 1'b1; WADR = 5'd9; WD = D_77;
        tick();
        WE = 1'b0; RE = 1'b1; RADR = 5'd9; SLEEP_EN = 8'h08;
        tick();
        checks++; if (rd0 !== D_77) begin errors++; $display("FAIL pre_rst_d0: got %h exp %h", rd0, D_77); end
        checks++; if (rdy0 !== 8'hF7) begin errors++; $display("FAIL pre_rst_rdy0: got %h exp f7", rdy0); end
        RE = 1'b0; RST = 1'b1;
        tick();
        checks++; if (vld0 !== 1'b0) begin errors++; $display("FAIL rst_mid_vld0: got %b exp 0", vld0); end
        checks++; if (rd0 !== D_0) begin errors++; $display("FAIL rst_mid_rd0: got %h exp %h", rd0, D_0); end
        checks++; if (vld1 !== 1'b0) begin errors++; $display("FAIL rst_mid_vld1: got %b exp 0", vld1); end
        checks++; if (rd1 !== D_0) begin errors++; $display("FAIL rst_mid_rd1: got %h exp %h", rd1, D_0); end
        checks++; if (rdy0 !== 8'hFF) begin errors++; $display("FAIL rst_mid_rdy0: got %h exp ff", rdy0); end
        RST = 1'b0; SLEEP_EN = 8'h00; RE = 1'b1; RADR = 5'd9;
        tick();
        RE = 1'b0;
        checks++; if (rd0 !== D_0) begin errors++; $display("FAIL post_rst_rd_d0: got %h exp %h", rd0, D_0); end
        checks++; if (vld0 !== 1'b1) begin errors++; $display("FAIL post_rst_vld0: got %b exp 1", vld0); end
        tick();
        checks++; if (rd1 !== D_0) begin errors++; $display("FAIL post_rst_rd_d1: got %h exp %h", rd1, D_0); end
        checks++; if (vld1 !== 1'b1) begin errors++; $display("FAIL post_rst_vld1: got %b exp 1", vld1); end
    endtask

    initial begin
        RST = 1'b1; RE = 1'b0; WE = 1'b0; RET_EN = 1'b0; IDDQ = 1'b0;
        RADR = '0; WADR = '0; WD = '0; SLEEP_EN = '0;
        test_reset();
        test_write_read();
        test_collision();
        WE = 1'b1; WADR = 5'd0; WD = D_5A;
        tick();
        WE = 1'b0;
        test_zone_sleep(1'b1, D_5A);
        test_zone_sleep(1'b0, D_0);
        test_wake_error();
        test_iddq();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rampdp_param.md
# rampdp_param

Parametrised two-port (1R/1W) RAM for accumulator and buffer storage. It generalises the fixed 32x256 two-port macro to any depth and width, a configurable number of power-gating zones, and an optional output pipeline stage. Unlike the fixed macro, it has real behaviour: per-zone sleep/wake state machines, retention control, write-to-read bypass and a read-valid strobe. It sits wherever a fixed two-port macro would, for example the accumulator data buffers.

## Interface
- DEPTH, 32, number of rows; must be a multiple of NZONE.
- WIDTH, 256, bits per row.
- AW, clog2(DEPTH), address width (derived).
- NZONE, 8, number of power zones; zone of address a = a / (DEPTH/NZONE).
- RD_PIPE, 0, 0 gives read latency 1; 1 adds an output register (latency 2).
- WAKE_CYC, 4, cycles from sleep release to zone ready (>=1).
- BYPASS, 1, 1 makes a same-address read/write return the new data; 0 returns the old data.
- CLK  in  1  clock.
- RST  in  1  reset, synchronous and active-high.
- RE  in  1  read enable.
- RADR  in  AW  read address.
- WE  in  1  write enable.
- WADR  in  AW  write address.
- WD  in  WIDTH  write data.
- RD  out  WIDTH  read data.
- RD_VLD  out  1  RD updated this cycle.
- ERR  out  1  one-cycle pulse: an access targeted a zone not in ON.
- SLEEP_EN  in  NZONE  per-zone sleep request (level).
- RET_EN  in  1  retention request, sampled when a zone enters OFF.
- ZONE_RDY  out  NZONE  zone is in ON.
- IDDQ  in  1  test mode: all accesses are suppressed.

## Operation
- **Storage and validity**
  - Storage array: DEPTH x WIDTH. It is not reset.
  - Per-row valid bit: cleared on RST; set by a successful write.
  - A read of a row whose valid bit is 0 returns all zeros.
- **Per-zone FSM**
  - States: ON, OFF, WAKE. Reset state is ON.
  - ON -> OFF when SLEEP_EN[z]=1.
  - OFF -> WAKE when SLEEP_EN[z]=0. On entering WAKE, load the counter with WAKE_CYC-1.
  - WAKE -> ON when the counter reaches 0; otherwise decrement.
  - WAKE -> OFF immediately if SLEEP_EN[z]=1.
  - On every entry to OFF: if RET_EN=0, clear the valid bits of all rows in the zone; if RET_EN=1, keep them.
  - ZONE_RDY[z] = (state==ON).
- **Write**
  - WE=1, IDDQ=0 and the target zone is ON: write WD to WADR and set its valid bit.
  - Target zone not ON: write is dropped and ERR pulses.
- **Read**
  - RE=1 and IDDQ=0 launches a read.
  - Target zone not ON: the returned data is 0, RD_VLD still asserts, and ERR pulses.
- **Collision** (RE and WE to the same address, same cycle, zone ON): BYPASS=1 returns WD; BYPASS=0 returns the prior content (0 if the row is invalid).
- **IDDQ=1**
  - RE and WE are ignored and no ERR is raised.
  - RD holds its value; RD_VLD=0.
  - Zone FSMs keep running.
- **Zone FSM vs access:** a zone FSM transition in cycle t affects accesses from cycle t+1. An access in the same cycle as ON->OFF completes normally.

## Timing
- Reset values: RD=0, RD_VLD=0, ERR=0, ZONE_RDY=all ones, all valid bits=0.
- Read latency: RE in cycle t gives RD and RD_VLD=1 at t+1 (RD_PIPE=0) or t+2 (RD_PIPE=1). RD holds between reads. Back-to-back reads give one result per cycle.
- Write visibility: a write in cycle t is visible to reads launched at t+1. At t itself, visibility follows BYPASS.
- ERR timing: ERR is aligned with RD_VLD for reads and asserts at t+1 for writes. If a read error and a write error fall in the same cycle, they merge into a single pulse.
- Wake timing: SLEEP_EN[z] falls at t, giving OFF->WAKE at t+1 and ZONE_RDY[z]=1 at t+1+WAKE_CYC.
- RST mid-operation: in-flight reads are discarded (RD_VLD=0 next cycle), all zones return to ON, and all valid bits are cleared.

## Test plan
- Reset, then write 0xA5.. to row 3 and read row 3 -> RD=0xA5.. at t+1 (RD_PIPE=0) or t+2 (RD_PIPE=1) with RD_VLD=1; reading the unwritten row 4 -> RD=0.
- Same-address RE+WE on row 7 (old=0x11.., new=0x22..) -> RD=0x22.. with BYPASS=1, 0x11.. with BYPASS=0.
- Set SLEEP_EN[0]=1 with RET_EN=1, release, wait WAKE_CYC=4 -> ZONE_RDY[0] high 5 cycles after release; row 0 still reads its prior value. Repeat with RET_EN=0 -> row 0 reads 0.
- Write or read zone 1 while it is in WAKE -> write dropped, read returns 0 with RD_VLD=1, ERR=1 for one cycle; zone 2 unaffected.
- IDDQ=1 with RE/WE active -> no write, RD_VLD=0, RD unchanged, ERR=0.
- Assert RST one cycle after RE -> RD_VLD=0, RD=0, ZONE_RDY all ones; a subsequent read of any row -> 0.
